gpio_event_capture: RTL and testbench
=====================================

// Module: gpio_event_capture
// PURPOSE
//   Consumes the DUT-driven GPIO pins (gpio_in side of GpioIf), synchronises them,
//   detects enabled rising/falling edges and queues timestamped event records in a
//   FIFO for the agent's monitor side to drain over a valid/ready port.
//   Sits directly downstream of the GPIO pin bundle; one record per cycle with edges.
// PARAMETERS
//   WIDTH        32  number of GPIO pins monitored (1..1024)
//   SYNC_STAGES   2  synchroniser flops per pin (>=2)
//   DEPTH        16  event FIFO entries (power of 2, >=2)
//   TS_WIDTH     16  free-running timestamp counter width
// PORTS
//   clk         in   1         clock
//   rst         in   1         synchronous reset, active-high
//   gpio_in     in   WIDTH     asynchronous pins driven by DUT
//   capture_en  in   1         1 = capture edges; 0 = disarm
//   rise_en     in   WIDTH     per-pin rising-edge enable
//   fall_en     in   WIDTH     per-pin falling-edge enable
//   ev_valid    out  1         FIFO head record valid
//   ev_ready    in   1         consumer accepts head record
//   ev_ts       out  TS_WIDTH  timestamp of head record
//   ev_rise     out  WIDTH     pins that rose (masked by rise_en)
//   ev_fall     out  WIDTH     pins that fell (masked by fall_en)
//   ev_level    out  WIDTH     synchronised pin levels at capture
//   ovf         out  1         sticky: record dropped on full FIFO
//   ovf_clr     in   1         clears ovf and drop_cnt
//   drop_cnt    out  8         dropped-record count, saturates at 255
// BEHAVIOUR
//   Reset: sync chain, prev register, ts counter, FIFO pointers, ovf, drop_cnt -> 0;
//     ev_valid=0; ev_ts/ev_rise/ev_fall/ev_level=0; FSM -> DISARMED.
//   Timestamp: ts increments every cycle after reset, wraps 2^TS_WIDTH-1 -> 0.
//   Synchroniser: gpio_in passes SYNC_STAGES flops -> s; prev <= s every cycle.
//   FSM:
//     DISARMED: no edge detection. capture_en=1 -> PRIME, prime_cnt=0.
//     PRIME: no edges reported for SYNC_STAGES+1 cycles (flush chain, load prev);
//       then -> RUN. capture_en=0 -> DISARMED.
//     RUN: rise=s&~prev&rise_en, fall=~s&prev&fall_en; if (rise|fall)!=0 push
//       {ts,rise,fall,s}. capture_en=0 -> DISARMED next cycle (no push that cycle).
//   Latency: pin toggle sampled at edge k -> pushed at edge k+SYNC_STAGES ->
//     ev_valid=1 in cycle after that edge (registered FIFO head, FWFT).
//   Handshake: pop on ev_valid&ev_ready; outputs stable while ev_valid&!ev_ready.
//   ev_valid=0 when FIFO empty; ev_* then hold last popped value.
//   Full: push with FIFO full and no pop that cycle -> record dropped, ovf<=1,
//     drop_cnt+=1 (saturating). Full with simultaneous pop -> push accepted.
//   Empty with push: record visible next cycle; no bypass in same cycle.
//   ovf_clr: ovf<=0, drop_cnt<=0; ovf_clr with simultaneous drop -> clear wins.
//   Enables changing mid-RUN take effect same cycle on the edge masks.
//   rst mid-operation: FIFO contents discarded, FSM DISARMED, ts restarts at 0.
//   Pin glitches shorter than a cycle are not guaranteed to be seen.
// TESTING
//   1) rst, capture_en=1, wait 4 cyc, gpio_in[3] 0->1 at ts=10 -> one record
//      ev_rise=0x8, ev_fall=0, ev_level=0x8, ev_ts=12, ev_valid 3 cyc after drive.
//   2) rise_en=0, fall_en=0xFF, pins 0x00->0x0F->0x00 -> only falling record,
//      ev_fall=0x0F, ev_rise=0; no record for the rise.
//   3) ev_ready=0, DEPTH=16, 20 toggle events -> 16 records held, ovf=1,
//      drop_cnt=4; then drain -> 16 records in order, ts strictly increasing.
//   4) FIFO full, toggle on same cycle as pop -> no drop, drop_cnt unchanged.
//   5) gpio_in=0xFF held, capture_en 0->1 -> no spurious rise in PRIME;
//      first record only after a genuine change.
//   6) rst asserted with 5 records queued -> ev_valid=0 next cycle, ts=0,
//      ovf=0; ts wrap 0xFFFF->0 recorded correctly in subsequent event.

Source files
------------

// File: rtl/gpio_event_capture.sv
// gpio_event_capture
//   Synchronises the DUT-driven GPIO pins, detects enabled rising/falling edges
//   while armed, and queues one timestamped record per cycle that has edges into
//   a first-word-fall-through FIFO. The FIFO head is registered and drained over
//   a valid/ready port.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   gpio_in   [WIDTH]         asynchronous pins from the DUT
//   capture_en                1 = arm edge capture, 0 = disarm
//   rise_en / fall_en [WIDTH] per-pin edge enables
//   ev_valid / ev_ready       head record handshake (pop on valid & ready)
//   ev_ts [TS_WIDTH]          timestamp of head record
//   ev_rise / ev_fall [WIDTH] masked edges of head record
//   ev_level [WIDTH]          synchronised pin levels at capture
//   ovf, ovf_clr              sticky drop flag and its clear
//   drop_cnt [8]              saturating dropped-record count
module gpio_event_capture #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 16,
  parameter int TS_WIDTH    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    gpio_in,
  input  logic                capture_en,
  input  logic [WIDTH-1:0]    rise_en,
  input  logic [WIDTH-1:0]    fall_en,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [TS_WIDTH-1:0] ev_ts,
  output logic [WIDTH-1:0]    ev_rise,
  output logic [WIDTH-1:0]    ev_fall,
  output logic [WIDTH-1:0]    ev_level,
  output logic                ovf,
  input  logic                ovf_clr,
  output logic [7:0]          drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(SYNC_STAGES + 1);
  localparam int RW = TS_WIDTH + 3 * WIDTH;

  localparam logic [TS_WIDTH-1:0] TS_ONE     = 1;
  localparam logic [PW-1:0]       PRIME_ONE  = 1;
  localparam logic [PW-1:0]       PRIME_LAST = PW'(SYNC_STAGES);
  localparam logic [CW-1:0]       FULL_CNT   = CW'(DEPTH);

  typedef enum logic [1:0] {DISARMED, PRIME, RUN} state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t               state, state_nxt;
  logic [PW-1:0]        prime_cnt, prime_cnt_nxt;
  logic [TS_WIDTH-1:0]  ts_cnt;
  logic [WIDTH-1:0]     sync_chain [SYNC_STAGES];
  logic [WIDTH-1:0]     lvl, prev_lvl;

  logic [WIDTH-1:0]     rise_p0, fall_p0;
  logic                 vld_p0;
  logic [RW-1:0]        rec_p0;

  logic [RW-1:0]        mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]        count, count_nxt;
  logic                 pop, full, push_ok, drop, head_from_push;
  logic [RW-1:0]        head_nxt, head_p1;

  // Free-running timestamp, synchroniser chain and previous-level register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt   <= '0;
      prev_lvl <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_chain[i] <= '0;
    end else begin
      ts_cnt        <= ts_cnt + TS_ONE;
      prev_lvl      <= lvl;
      sync_chain[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_chain[i] <= sync_chain[i-1];
    end
  end

  assign lvl = sync_chain[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DISARMED;
      prime_cnt <= '0;
    end else begin
      state     <= state_nxt;
      prime_cnt <= prime_cnt_nxt;
    end
  end

  // PRIME holds off reporting for SYNC_STAGES+1 cycles so the chain and
  // prev_lvl carry real pin history before edges are trusted.
  always_comb begin
    state_nxt     = state;
    prime_cnt_nxt = prime_cnt;
    case (state)
      DISARMED: begin
        if (capture_en) begin
          state_nxt     = PRIME;
          prime_cnt_nxt = '0;
        end
      end
      PRIME: begin
        if (!capture_en)              state_nxt = DISARMED;
        else if (prime_cnt == PRIME_LAST) state_nxt = RUN;
        else                          prime_cnt_nxt = prime_cnt + PRIME_ONE;
      end
      RUN: begin
        if (!capture_en) state_nxt = DISARMED;
      end
      default: state_nxt = DISARMED;
    endcase
  end

  // p0: edge detection and record assembly
  assign rise_p0 = lvl & ~prev_lvl & rise_en;
  assign fall_p0 = ~lvl & prev_lvl & fall_en;
  assign vld_p0  = (state == RUN) && capture_en && (|(rise_p0 | fall_p0));
  assign rec_p0  = {ts_cnt, rise_p0, fall_p0, lvl};

  // FIFO control. A pop frees a slot in the same cycle, so a full FIFO
  // still accepts a push when the consumer takes the head.
  assign pop        = ev_valid & ev_ready;
  assign full       = (count == FULL_CNT);
  assign push_ok    = vld_p0 && (!full || pop);
  assign drop       = vld_p0 && full && !pop;
  assign rd_ptr_nxt = rd_ptr + AW'(pop);
  assign count_nxt  = count + CW'(push_ok) - CW'(pop);

  // When the stored entries are exhausted by this cycle's pop (or none were
  // stored), the next head can only be the record being written now.
  assign head_from_push = (count == CW'(pop));
  assign head_nxt       = head_from_push ? rec_p0 : mem[rd_ptr_nxt];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rec_p0;
  end

  // p1: registered FIFO head and status
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ev_valid <= 1'b0;
      head_p1  <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(push_ok);
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      ev_valid <= (count_nxt != '0);
      // Head holds the last popped record once the FIFO runs empty.
      if (count_nxt != '0) head_p1 <= head_nxt;
      if (ovf_clr) begin
        ovf      <= 1'b0;
        drop_cnt <= '0;
      end else if (drop) begin
        ovf      <= 1'b1;
        drop_cnt <= sat_inc8(drop_cnt);
      end
    end
  end

  assign ev_ts    = head_p1[RW-1 -: TS_WIDTH];
  assign ev_rise  = head_p1[3*WIDTH-1 -: WIDTH];
  assign ev_fall  = head_p1[2*WIDTH-1 -: WIDTH];
  assign ev_level = head_p1[WIDTH-1:0];

endmodule

// File: tb/tb_gpio_event_capture.sv
// tb_gpio_event_capture
//   Directed scenarios plus a randomized phase for gpio_event_capture. A
//   behavioural model tracks pin history, armed time, timestamp and a record
//   queue, and is compared against the DUT every cycle.
module tb_gpio_event_capture;

  localparam int W     = 32;
  localparam int SYNC  = 2;
  localparam int DEPTH = 16;
  localparam int TSW   = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   gpio_in;
  logic           capture_en;
  logic [W-1:0]   rise_en, fall_en;
  logic           ev_valid, ev_ready;
  logic [TSW-1:0] ev_ts;
  logic [W-1:0]   ev_rise, ev_fall, ev_level;
  logic           ovf, ovf_clr;
  logic [7:0]     drop_cnt;

  gpio_event_capture #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .DEPTH(DEPTH), .TS_WIDTH(TSW)
  ) dut (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .capture_en(capture_en),
    .rise_en(rise_en), .fall_en(fall_en), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_ts(ev_ts), .ev_rise(ev_rise), .ev_fall(ev_fall),
    .ev_level(ev_level), .ovf(ovf), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [TSW-1:0] ts;
    logic [W-1:0]   rise;
    logic [W-1:0]   fall;
    logic [W-1:0]   level;
  } rec_t;

  rec_t         q[$];
  rec_t         last_pop;
  rec_t         nrec;
  rec_t         hd;
  logic [W-1:0] smp [0:SYNC];   // smp[0] = pin value sampled at the latest edge
  logic [W-1:0] m_s, m_p, m_r, m_f;
  int           streak;          // consecutive edges with capture_en high
  int           ts_m;
  bit           ovf_m;
  int           drop_m;
  bit           model_ok = 0;
  bit           m_pop, m_push;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      last_pop = '0;
      streak   = 0;
      ts_m     = 0;
      ovf_m    = 0;
      drop_m   = 0;
      for (int i = 0; i <= SYNC; i++) smp[i] = '0;
      model_ok = 1;
    end else begin
      // Pin level seen by the detector lags the pin by SYNC edges.
      m_s = smp[SYNC-1];
      m_p = smp[SYNC];
      m_r = m_s & ~m_p & rise_en;
      m_f = ~m_s & m_p & fall_en;
      if (capture_en) begin
        if (streak < 100000) streak++;
      end else begin
        streak = 0;
      end
      // One DISARMED edge, SYNC+1 PRIME edges, then capture.
      m_push = capture_en && (streak >= SYNC + 3) && ((m_r | m_f) != '0);
      m_pop  = (q.size() != 0) && ev_ready;
      if (m_pop) last_pop = q.pop_front();
      if (m_push) begin
        if (q.size() == DEPTH) begin
          if (!ovf_clr) begin
            ovf_m  = 1;
            drop_m = (drop_m < 255) ? drop_m + 1 : 255;
          end
        end else begin
          nrec.ts    = TSW'(ts_m);
          nrec.rise  = m_r;
          nrec.fall  = m_f;
          nrec.level = m_s;
          q.push_back(nrec);
        end
      end
      if (ovf_clr) begin
        ovf_m  = 0;
        drop_m = 0;
      end
      for (int i = SYNC; i > 0; i--) smp[i] = smp[i-1];
      smp[0] = gpio_in;
      ts_m = (ts_m + 1) % (1 << TSW);
    end
    #1;
    if (model_ok) begin
      hd = (q.size() != 0) ? q[0] : last_pop;
      check_eq("m_valid", ev_valid, q.size() != 0);
      check_eq("m_ts", ev_ts, hd.ts);
      check_eq("m_rise", ev_rise, hd.rise);
      check_eq("m_fall", ev_fall, hd.fall);
      check_eq("m_level", ev_level, hd.level);
      check_eq("m_ovf", ovf, ovf_m);
      check_eq("m_drop", drop_cnt, drop_m);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [TSW-1:0] tsr [32];
  int             n;

  initial begin
    rst = 1; gpio_in = '0; capture_en = 0; rise_en = '1; fall_en = '1;
    ev_ready = 0; ovf_clr = 0;
    step(3);

    // Single rising edge on pin 3 sampled at ts=10.
    rst = 0; capture_en = 1;
    check_eq("rst_valid", ev_valid, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_drop", drop_cnt, 0);
    step(10);
    gpio_in = 32'h8;
    step(2);
    check_eq("t1_early", ev_valid, 0);
    step(1);
    check_eq("t1_valid", ev_valid, 1);
    check_eq("t1_ts", ev_ts, 12);
    check_eq("t1_rise", ev_rise, 32'h8);
    check_eq("t1_fall", ev_fall, 0);
    check_eq("t1_level", ev_level, 32'h8);
    ev_ready = 1; step(1); ev_ready = 0;
    check_eq("t1_popped", ev_valid, 0);

    // Falling edges only.
    rise_en = '0; fall_en = '0; gpio_in = '0;
    step(5);
    fall_en = 32'hFF; gpio_in = 32'h0F;
    step(6);
    check_eq("t2_norise", ev_valid, 0);
    gpio_in = '0;
    step(3);
    check_eq("t2_valid", ev_valid, 1);
    check_eq("t2_fall", ev_fall, 32'h0F);
    check_eq("t2_rise", ev_rise, 0);
    check_eq("t2_level", ev_level, 0);
    ev_ready = 1; step(1); ev_ready = 0;
    rise_en = '1; fall_en = '1;
    step(1);

    // Overflow: 20 events into a 16-entry FIFO, then drain in order.
    for (int i = 0; i < 20; i++) begin
      gpio_in[0] = ~gpio_in[0];
      step(2);
    end
    step(4);
    check_eq("t3_ovf", ovf, 1);
    check_eq("t3_drop", drop_cnt, 4);
    check_eq("t3_valid", ev_valid, 1);
    ev_ready = 1; n = 0;
    for (int i = 0; i < 40; i++) begin
      if (ev_valid && n < 32) begin
        tsr[n] = ev_ts;
        n++;
      end
      step(1);
    end
    ev_ready = 0;
    check_eq("t3_count", n, 16);
    for (int i = 1; i < n; i++) check_eq("t3_order", tsr[i] > tsr[i-1], 1);

    // Full FIFO with a push on the same cycle as a pop: nothing dropped.
    ovf_clr = 1; step(1); ovf_clr = 0;
    check_eq("t4_clr_ovf", ovf, 0);
    check_eq("t4_clr_drop", drop_cnt, 0);
    for (int i = 0; i < 16; i++) begin
      gpio_in[0] = ~gpio_in[0];
      step(2);
    end
    step(4);
    check_eq("t4_full_valid", ev_valid, 1);
    check_eq("t4_full_drop", drop_cnt, 0);
    gpio_in[0] = ~gpio_in[0];
    step(2);
    ev_ready = 1; step(1); ev_ready = 0;
    step(3);
    check_eq("t4_drop", drop_cnt, 0);
    check_eq("t4_ovf", ovf, 0);
    ev_ready = 1; n = 0;
    for (int i = 0; i < 40; i++) begin
      if (ev_valid) n++;
      step(1);
    end
    ev_ready = 0;
    check_eq("t4_count", n, 16);

    // Arming with pins already high: no spurious rise.
    capture_en = 0; gpio_in = 32'hFF;
    step(5);
    capture_en = 1;
    step(10);
    check_eq("t5_quiet", ev_valid, 0);
    gpio_in = 32'hFE;
    step(3);
    check_eq("t5_valid", ev_valid, 1);
    check_eq("t5_fall", ev_fall, 32'h1);
    check_eq("t5_rise", ev_rise, 0);
    check_eq("t5_level", ev_level, 32'hFE);
    ev_ready = 1; step(1); ev_ready = 0;

    // Reset with records queued, then timestamp restart and wrap.
    for (int i = 0; i < 5; i++) begin
      gpio_in[8] = ~gpio_in[8];
      step(2);
    end
    step(4);
    check_eq("t6_queued", ev_valid, 1);
    gpio_in = '0; rst = 1;
    step(1);
    check_eq("t6_valid", ev_valid, 0);
    check_eq("t6_ovf", ovf, 0);
    check_eq("t6_ts", ev_ts, 0);
    rst = 0;
    step(10);
    gpio_in = 32'h1;
    step(3);
    check_eq("t6_restart", ev_ts, 12);
    ev_ready = 1; step(1); ev_ready = 0;
    step(4079);
    gpio_in = gpio_in ^ 32'h2;
    step(2);
    gpio_in = gpio_in ^ 32'h4;
    step(1);
    check_eq("t6_pre_valid", ev_valid, 1);
    check_eq("t6_pre_ts", ev_ts, 12'hFFF);
    check_eq("t6_pre_rise", ev_rise, 32'h2);
    ev_ready = 1; step(1); ev_ready = 0;
    step(1);
    check_eq("t6_wrap_valid", ev_valid, 1);
    check_eq("t6_wrap_ts", ev_ts, 1);
    check_eq("t6_wrap_rise", ev_rise, 32'h4);

    // Randomized traffic.
    rst = 1; step(2); rst = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) gpio_in = gpio_in ^ (32'h1 << $urandom_range(7));
      if ($urandom_range(31) == 0) rise_en = $urandom;
      if ($urandom_range(31) == 0) fall_en = $urandom;
      if (i < 1200) ev_ready = ($urandom_range(7) == 0);
      else          ev_ready = ($urandom_range(2) != 0);
      capture_en = ($urandom_range(99) != 0);
      ovf_clr    = ($urandom_range(63) == 0);
      rst        = ($urandom_range(599) == 0);
      step(1);
    end
    rst = 0; ovf_clr = 0; ev_ready = 0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
